// File: rtl/uart_sipo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_sipo_if
// Brief    : Serial line, frame config and received-byte bundle for uart_sipo.
// Revision : 1.0
// ============================================================================
interface uart_sipo_if;
    logic       data_rx;
    logic [1:0] parity_type;
    logic [7:0] data_out;
    logic       done_flag;
    logic       active_flag;
    logic       parity_error;
    logic       stop_error;

    modport master (
        output data_rx, parity_type,
        input  data_out, done_flag, active_flag, parity_error, stop_error
    );

    modport slave (
        input  data_rx, parity_type,
        output data_out, done_flag, active_flag, parity_error, stop_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_sipo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_sipo
// Brief    : UART receive deserializer, 16x oversampled, optional parity.
// Revision : 1.0
// ============================================================================
module uart_sipo #(
    parameter int OVERSAMPLE = 16
) (
    input  wire logic   baud_clk,
    input  wire logic   reset_n,
    uart_sipo_if.slave  bus
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(OVERSAMPLE / 2 - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic               r_sync1;
    logic               r_rx_s;
    logic               r_rx_prev;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_shift;
    logic [1:0]         r_ptype;
    logic               r_p;
    logic [7:0]         r_data_out;
    logic               r_done;
    logic               r_active;
    logic               r_perr;
    logic               r_serr;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         w_shift_nxt;
    logic [1:0]         w_ptype_nxt;
    logic               w_p_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_done_nxt;
    logic               w_active_nxt;
    logic               w_perr_nxt;
    logic               w_serr_nxt;
    logic               w_cnt_end;
    logic               w_par_en;

    assign w_cnt_end = (r_cnt == c_CNT_LAST);
    assign w_par_en  = (r_ptype == 2'b01) || (r_ptype == 2'b10);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_ptype_nxt = r_ptype;
        w_p_nxt     = r_p;
        w_data_nxt  = r_data_out;
        w_perr_nxt  = r_perr;
        w_serr_nxt  = r_serr;
        w_done_nxt  = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (r_rx_prev && !r_rx_s) begin
                    w_state_nxt = c_START;
                end
            end
            c_START: begin
                if (r_cnt == c_CNT_MID) begin
                    w_cnt_nxt = '0;
                    if (!r_rx_s) begin
                        w_state_nxt = c_DATA;
                        w_idx_nxt   = 3'd0;
                        w_ptype_nxt = bus.parity_type;
                    end else begin
                        // Start bit gone by mid-bit: treat as line noise
                        w_state_nxt = c_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_DATA: begin
                if (w_cnt_end) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = w_par_en ? c_PARITY : c_STOP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_PARITY: begin
                if (w_cnt_end) begin
                    w_cnt_nxt   = '0;
                    w_p_nxt     = r_rx_s;
                    w_state_nxt = c_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            c_STOP: begin
                if (w_cnt_end) begin
                    w_cnt_nxt   = '0;
                    w_data_nxt  = r_shift;
                    w_serr_nxt  = ~r_rx_s;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_IDLE;
                    case (r_ptype)
                        2'b10:   w_perr_nxt = ^{r_shift, r_p};
                        2'b01:   w_perr_nxt = ~^{r_shift, r_p};
                        default: w_perr_nxt = 1'b0;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
                w_idx_nxt   = 3'd0;
            end
        endcase

        w_active_nxt = (w_state_nxt != c_IDLE);
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_state    <= c_IDLE;
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_shift    <= 8'h00;
            r_ptype    <= 2'b00;
            r_p        <= 1'b0;
            r_data_out <= 8'h00;
            r_done     <= 1'b0;
            r_active   <= 1'b0;
            r_perr     <= 1'b0;
            r_serr     <= 1'b0;
        end else begin
            r_sync1    <= bus.data_rx;
            r_rx_s     <= r_sync1;
            r_rx_prev  <= r_rx_s;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_shift    <= w_shift_nxt;
            r_ptype    <= w_ptype_nxt;
            r_p        <= w_p_nxt;
            r_data_out <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_active   <= w_active_nxt;
            r_perr     <= w_perr_nxt;
            r_serr     <= w_serr_nxt;
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.done_flag    = r_done;
    assign bus.active_flag  = r_active;
    assign bus.parity_error = r_perr;
    assign bus.stop_error   = r_serr;

endmodule
`default_nettype wire

// File: tb/tb_uart_sipo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_sipo
// Brief    : Directed and randomized frame bench for uart_sipo.
// Revision : 1.0
// ============================================================================
module tb_uart_sipo;

    localparam int OS = 16;

    logic baud_clk = 1'b0;
    logic reset_n;

    uart_sipo_if bus ();

    uart_sipo #(.OVERSAMPLE(OS)) dut (
        .baud_clk (baud_clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    always #5 baud_clk = ~baud_clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         done_total = 0;
    int         act_total  = 0;
    logic [7:0] cap_data   = 8'h00;
    logic       cap_pe     = 1'b0;
    logic       cap_se     = 1'b0;
    logic       cap_act    = 1'b0;

    always @(negedge baud_clk) begin
        if (bus.done_flag === 1'b1) begin
            done_total = done_total + 1;
            cap_data   = bus.data_out;
            cap_pe     = bus.parity_error;
            cap_se     = bus.stop_error;
            cap_act    = bus.active_flag;
        end
        if (bus.active_flag === 1'b1) act_total = act_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input int ticks);
        bus.data_rx = v;
        repeat (ticks) @(negedge baud_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pt,
                              input logic p, input logic stop);
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        if (pt == 2'b01 || pt == 2'b10) drive(p, OS);
        drive(stop, OS);
    endtask

    // Parity rule stated on bit counts: even wants an even total of ones
    function automatic logic exp_perr(input logic [7:0] d, input logic [1:0] pt, input logic p);
        int ones;
        ones = $countones(d) + int'(p);
        if (pt == 2'b10) return (ones % 2) != 0;
        if (pt == 2'b01) return (ones % 2) == 0;
        return 1'b0;
    endfunction

    task automatic check_frame(input string tag, input int done_before,
                               input logic [7:0] d, input logic pe, input logic se);
        check($sformatf("%s_done", tag), 32'(done_total - done_before), 32'd1);
        check($sformatf("%s_data", tag), {24'd0, cap_data}, {24'd0, d});
        check($sformatf("%s_perr", tag), {31'd0, cap_pe}, {31'd0, pe});
        check($sformatf("%s_serr", tag), {31'd0, cap_se}, {31'd0, se});
        check($sformatf("%s_act_at_done", tag), {31'd0, cap_act}, 32'd0);
    endtask

    initial begin
        int         d0;
        int         a0;
        logic [7:0] dbyte;
        logic [1:0] pt;
        logic       p;
        logic       stop;

        bus.data_rx     = 1'b1;
        bus.parity_type = 2'b00;
        reset_n         = 1'b0;
        repeat (5) @(negedge baud_clk);
        check("rst_data", {24'd0, bus.data_out}, 32'd0);
        check("rst_done", {31'd0, bus.done_flag}, 32'd0);
        check("rst_active", {31'd0, bus.active_flag}, 32'd0);
        check("rst_perr", {31'd0, bus.parity_error}, 32'd0);
        check("rst_serr", {31'd0, bus.stop_error}, 32'd0);
        reset_n = 1'b1;
        drive(1'b1, 2 * OS);

        d0 = done_total;
        send_frame(8'hA5, 2'b00, 1'b0, 1'b1);
        check_frame("a5_nopar", d0, 8'hA5, 1'b0, 1'b0);
        drive(1'b1, OS);
        check("a5_active_after", {31'd0, bus.active_flag}, 32'd0);

        bus.parity_type = 2'b10;
        d0 = done_total;
        send_frame(8'h3C, 2'b10, 1'b0, 1'b1);
        check_frame("3c_even_p0", d0, 8'h3C, 1'b0, 1'b0);
        drive(1'b1, OS);
        d0 = done_total;
        send_frame(8'h3C, 2'b10, 1'b1, 1'b1);
        check_frame("3c_even_p1", d0, 8'h3C, 1'b1, 1'b0);
        drive(1'b1, OS);
        bus.parity_type = 2'b01;
        d0 = done_total;
        send_frame(8'h01, 2'b01, 1'b0, 1'b1);
        check_frame("01_odd_p0", d0, 8'h01, 1'b0, 1'b0);
        drive(1'b1, OS);

        bus.parity_type = 2'b00;
        d0 = done_total;
        send_frame(8'h55, 2'b00, 1'b0, 1'b0);
        check_frame("55_stop0", d0, 8'h55, 1'b0, 1'b1);
        d0 = done_total;
        drive(1'b0, 3 * OS);
        check("break_no_done", 32'(done_total - d0), 32'd0);
        check("break_active", {31'd0, bus.active_flag}, 32'd0);
        drive(1'b1, 2 * OS);

        d0 = done_total;
        a0 = act_total;
        drive(1'b0, 4);
        drive(1'b1, 2 * OS);
        check("glitch_no_done", 32'(done_total - d0), 32'd0);
        check("glitch_data_kept", {24'd0, bus.data_out}, 32'h55);
        check("glitch_act_pulse_le8", {31'd0, (act_total - a0) <= 8 && (act_total - a0) > 0}, 32'd1);

        d0 = done_total;
        send_frame(8'h00, 2'b00, 1'b0, 1'b1);
        check_frame("b2b_00", d0, 8'h00, 1'b0, 1'b0);
        d0 = done_total;
        send_frame(8'hFF, 2'b00, 1'b0, 1'b1);
        check_frame("b2b_ff", d0, 8'hFF, 1'b0, 1'b0);
        drive(1'b1, OS);

        d0 = done_total;
        drive(1'b0, OS);
        drive(1'b1, OS);
        drive(1'b0, OS);
        drive(1'b0, OS);
        drive(1'b1, OS / 2);
        reset_n = 1'b0;
        #1;
        check("midrst_data", {24'd0, bus.data_out}, 32'd0);
        check("midrst_active", {31'd0, bus.active_flag}, 32'd0);
        check("midrst_done", {31'd0, bus.done_flag}, 32'd0);
        bus.data_rx = 1'b1;
        repeat (4) @(negedge baud_clk);
        reset_n = 1'b1;
        drive(1'b1, 12 * OS);
        check("midrst_no_done", 32'(done_total - d0), 32'd0);
        d0 = done_total;
        send_frame(8'h81, 2'b00, 1'b0, 1'b1);
        check_frame("after_rst_81", d0, 8'h81, 1'b0, 1'b0);
        drive(1'b1, OS);

        for (int k = 0; k < 24; k++) begin
            dbyte = 8'($urandom);
            pt    = 2'($urandom_range(0, 3));
            p     = 1'($urandom);
            stop  = ($urandom_range(0, 3) != 0);
            bus.parity_type = pt;
            d0 = done_total;
            send_frame(dbyte, pt, p, stop);
            check_frame($sformatf("rnd%0d", k), d0, dbyte, exp_perr(dbyte, pt, p), ~stop);
            drive(1'b1, int'($urandom_range(2, 20)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
